// File: rtl/data_mem_io.sv
// rtl/data_mem_io.sv - data-side memory stage: general RAM plus screen, number display, LFSR and controller MMIO
//
// Purpose: serves CPU data accesses with one cycle of read latency.
//   Addresses 0..RAM_DEPTH-1 are byte RAM.
//   Addresses 240..255 are memory-mapped peripherals:
//     - a double-buffered pixel screen
//     - a number display latch
//     - an 8-bit Galois LFSR
//     - a controller input sample
// Ports:
//   clk, sync_rst        clock and synchronous active-high reset
//   clk_en               global stall; all state holds when low
//   mem_req, mem_we      access strobe and write select
//   data_address         byte address
//   data_in              write data from the CPU
//   data_out             registered read data to the CPU
//   controller           button state, sampled on every enabled cycle
//   number_value, number_valid, number_signed
//                        number display latch
//   scr_x, scr_y         display scan position
//   scr_pixel            front-buffer bit at the scan position (combinational)
module data_mem_io #(
  parameter int         RAM_DEPTH = 240,
  parameter logic [7:0] LFSR_SEED = 8'h01,
  parameter int         SCR_BITS  = 5
) (
  input  logic                clk,
  input  logic                sync_rst,
  input  logic                clk_en,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [7:0]          data_address,
  input  logic [7:0]          data_in,
  output logic [7:0]          data_out,
  input  logic [7:0]          controller,
  output logic [7:0]          number_value,
  output logic                number_valid,
  output logic                number_signed,
  input  logic [SCR_BITS-1:0] scr_x,
  input  logic [SCR_BITS-1:0] scr_y,
  output logic                scr_pixel
);

  localparam int         PIX_N     = (1 << SCR_BITS) * (1 << SCR_BITS);
  localparam int         RAM_IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [8:0] RAM_TOP   = 9'(RAM_DEPTH);

  logic [7:0]            ram [RAM_DEPTH];
  logic [PIX_N-1:0]      front;
  logic [PIX_N-1:0]      back;
  logic [SCR_BITS-1:0]   pix_x;
  logic [SCR_BITS-1:0]   pix_y;
  logic [7:0]            lfsr;
  logic [7:0]            lfsr_next;
  logic [7:0]            ctrl_q;
  logic [7:0]            rd_data;
  logic                  is_ram;
  logic [RAM_IDX_W-1:0]  ram_idx;
  logic [2*SCR_BITS-1:0] pix_idx;
  logic                  access;

  assign is_ram  = {1'b0, data_address} < RAM_TOP;
  assign ram_idx = RAM_IDX_W'(data_address);

  // Pixels are addressed as {x, y} in the flattened buffers.
  assign pix_idx   = {pix_x, pix_y};
  assign scr_pixel = front[{scr_x, scr_y}];
  assign access    = clk_en && mem_req;

  // Right-shifting Galois LFSR for x^8+x^6+x^5+x^4+1.
  // Starting from a non-zero seed it never reaches zero.
  assign lfsr_next = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);

  always_comb begin
    rd_data = 8'h00;
    if (is_ram) begin
      rd_data = ram[ram_idx];
    end else begin
      case (data_address)
        8'd244:  rd_data = {7'b0, back[pix_idx]};
        8'd254:  rd_data = lfsr;
        8'd255:  rd_data = ctrl_q;
        default: rd_data = 8'h00;
      endcase
    end
  end

  // RAM contents survive reset, so the array lives in its own block.
  always_ff @(posedge clk) begin
    if (!sync_rst && access && mem_we && is_ram) begin
      ram[ram_idx] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      data_out      <= 8'h00;
      number_value  <= 8'h00;
      number_valid  <= 1'b0;
      number_signed <= 1'b0;
      lfsr          <= LFSR_SEED;
      pix_x         <= '0;
      pix_y         <= '0;
      ctrl_q        <= 8'h00;
      front         <= '0;
      back          <= '0;
    end else if (clk_en) begin
      ctrl_q <= controller;
      if (mem_req) begin
        if (mem_we) begin
          if (!is_ram) begin
            case (data_address)
              8'd240:  pix_x <= data_in[SCR_BITS-1:0];
              8'd241:  pix_y <= data_in[SCR_BITS-1:0];
              8'd242:  back[pix_idx] <= 1'b1;
              8'd243:  back[pix_idx] <= 1'b0;
              8'd245:  front <= back;
              8'd246:  back <= '0;
              8'd250: begin
                number_value <= data_in;
                number_valid <= 1'b1;
              end
              8'd251:  number_valid <= 1'b0;
              8'd252:  number_signed <= 1'b1;
              8'd253:  number_signed <= 1'b0;
              default: ;
            endcase
          end
        end else begin
          data_out <= rd_data;
          // The LFSR value is returned first, then advanced on the same edge.
          if (!is_ram && data_address == 8'd254) begin
            lfsr <= lfsr_next;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_io.sv
// tb/tb_data_mem_io.sv - self-checking bench for data_mem_io
module tb_data_mem_io;

  logic       clk = 1'b0;
  logic       sync_rst, clk_en, mem_req, mem_we;
  logic [7:0] data_address, data_in, data_out, controller;
  logic [7:0] number_value;
  logic       number_valid, number_signed;
  logic [4:0] scr_x, scr_y;
  logic       scr_pixel;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_mem_io dut (
    .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en), .mem_req(mem_req),
    .mem_we(mem_we), .data_address(data_address), .data_in(data_in),
    .data_out(data_out), .controller(controller), .number_value(number_value),
    .number_valid(number_valid), .number_signed(number_signed),
    .scr_x(scr_x), .scr_y(scr_y), .scr_pixel(scr_pixel)
  );

  typedef struct {
    logic       rst, en, req, we;
    logic [7:0] addr, din, exp;
  } vec_t;

  vec_t vt[11];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic r, input logic e, input logic q, input logic w,
                     input logic [7:0] a, input logic [7:0] d);
    sync_rst = r; clk_en = e; mem_req = q; mem_we = w; data_address = a; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [7:0] a);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, a, 8'h00);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  logic [7:0] first_vals[3];
  int         zeros;

  initial begin
    sync_rst = 1'b1; clk_en = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    data_address = 8'h00; data_in = 8'h00; controller = 8'h00;
    scr_x = 5'd0; scr_y = 5'd0;

    // Reset with clk_en low must still take effect.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    do_reset();
    check8("rst_data_out", data_out, 8'h00);
    check8("rst_num_value", number_value, 8'h00);
    check8("rst_num_flags", {6'b0, number_valid, number_signed}, 8'h00);
    check8("rst_scr_pixel", {7'b0, scr_pixel}, 8'h00);

    //           rst   en    req   we    addr    din     exp data_out
    vt[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd17,  8'h5A, 8'h00};
    vt[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd17,  8'h00, 8'h5A};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd18,  8'h33, 8'h5A};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd18,  8'h00, 8'h33};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd17,  8'hC3, 8'h33};
    vt[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd17,  8'h00, 8'hC3};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd18,  8'h00, 8'hC3};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd247, 8'h00, 8'h00};
    vt[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd249, 8'hFF, 8'h00};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd239, 8'h00, 8'h00};
    vt[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd17,  8'h00, 8'h00};
    // vt[9] reads the top RAM byte after it is written below.
    wr(8'd239, 8'h00);
    for (int i = 0; i < 11; i++) begin
      cyc(vt[i].rst, vt[i].en, vt[i].req, vt[i].we, vt[i].addr, vt[i].din);
      check8($sformatf("vec%0d", i), data_out, vt[i].exp);
    end

    // Stall: read held with clk_en low for three cycles.
    do_reset();
    wr(8'd17, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'd17, 8'h00);
      check8($sformatf("stall%0d", i), data_out, 8'h00);
    end
    rd(8'd17);
    check8("stall_release", data_out, 8'h5A);

    // Screen double buffer.
    scr_x = 5'd3; scr_y = 5'd7;
    wr(8'd240, 8'd3);
    wr(8'd241, 8'd7);
    wr(8'd242, 8'h00);
    rd(8'd244);
    check8("back_set", data_out, 8'h01);
    check8("front_before_copy", {7'b0, scr_pixel}, 8'h00);
    wr(8'd245, 8'h00);
    check8("front_after_copy", {7'b0, scr_pixel}, 8'h01);
    wr(8'd246, 8'h00);
    rd(8'd244);
    check8("back_cleared", data_out, 8'h00);
    check8("front_kept", {7'b0, scr_pixel}, 8'h01);
    // X/Y truncate to 5 bits: 0xFF selects pixel 31.
    scr_x = 5'd31; scr_y = 5'd31;
    wr(8'd240, 8'hFF);
    wr(8'd241, 8'hFF);
    wr(8'd242, 8'h00);
    wr(8'd245, 8'h00);
    check8("pixel_31_31", {6'b0, scr_pixel, 1'b0} | {7'b0, dut.front[{5'd3, 5'd7}]} , 8'h02);
    wr(8'd243, 8'h00);
    rd(8'd244);
    check8("back_clear_31", data_out, 8'h00);

    // Number display latch.
    wr(8'd250, 8'hF6);
    wr(8'd252, 8'h00);
    check8("num_value", number_value, 8'hF6);
    check8("num_flags_set", {6'b0, number_valid, number_signed}, 8'h03);
    wr(8'd251, 8'h00);
    check8("num_value_kept", number_value, 8'hF6);
    check8("num_valid_clr", {6'b0, number_valid, number_signed}, 8'h01);
    wr(8'd253, 8'h00);
    check8("num_signed_clr", {6'b0, number_valid, number_signed}, 8'h00);

    // LFSR: writes to 254/255 change nothing, then a full period.
    do_reset();
    wr(8'd254, 8'hFF);
    wr(8'd255, 8'hFF);
    zeros = 0;
    for (int i = 0; i < 255; i++) begin
      rd(8'd254);
      if (i < 3) first_vals[i] = data_out;
      if (data_out == 8'h00) zeros++;
      // Idle cycles in between must not advance the LFSR.
      if (i == 1) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd254, 8'h00);
    end
    check8("lfsr_0", first_vals[0], 8'h01);
    check8("lfsr_1", first_vals[1], 8'hB8);
    check8("lfsr_2", first_vals[2], 8'h5C);
    check8("lfsr_no_zero", 8'(zeros), 8'h00);
    rd(8'd254);
    check8("lfsr_period", data_out, 8'h01);

    // Controller sample: one cycle delay, frozen under stall.
    controller = 8'h21;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    controller = 8'h44;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    rd(8'd255);
    check8("ctrl_sample", data_out, 8'h21);
    rd(8'd255);
    check8("ctrl_sample2", data_out, 8'h44);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/data_mem_io.md
Name: data_mem_io

Overview:
- Data-side memory stage directly downstream of the CPU data port. It consumes data_address, data_out, mem_we and mem_req, and produces the byte the CPU samples on data_in.
- Address space is 8 bits. Addresses 0..239 map to general RAM. Addresses 240..255 map to memory-mapped peripherals: a 32x32 double-buffered pixel screen, a number display latch, an 8-bit LFSR random number generator and a controller input port.
- Read latency is one cycle, matching the instruction ROM timing.

Parameters:
- RAM_DEPTH, 240, number of general RAM bytes; RAM occupies addresses 0..RAM_DEPTH-1.
- LFSR_SEED, 8'h01, LFSR value on reset; must be non-zero.
- SCR_BITS, 5, screen coordinate width; screen is 2^SCR_BITS pixels square.

Ports:
- clk, input, 1, system clock.
- sync_rst, input, 1, synchronous active-high reset.
- clk_en, input, 1, global stall; all state holds when low.
- mem_req, input, 1, CPU data access this cycle.
- mem_we, input, 1, write strobe; meaningful only with mem_req.
- data_address, input, 8, byte address.
- data_in, input, 8, write data from the CPU data_out.
- data_out, output, 8, registered read data to the CPU data_in.
- controller, input, 8, button state from the board.
- number_value, output, 8, latched number for the display.
- number_valid, output, 1, display shows number_value when high.
- number_signed, output, 1, display interprets the value as two's complement when high.
- scr_x, input, SCR_BITS, display scan column.
- scr_y, input, SCR_BITS, display scan row.
- scr_pixel, output, 1, front-buffer bit at (scr_x, scr_y); combinational.

Behaviour:
- Reset, when sync_rst is high at a clock edge, regardless of clk_en:
  - data_out = 0, number_value = 0, number_valid = 0, number_signed = 0.
  - LFSR = LFSR_SEED, pixel X/Y = 0, controller sample = 0.
  - Front and back buffers cleared.
  - RAM contents are not cleared.
  - Reset takes priority over any concurrent access.
- Gating: when clk_en = 0, nothing updates, including data_out, the LFSR and the controller sample. When clk_en = 1 and mem_req = 0, only the controller sample updates; data_out holds.
- Access: an access occurs on a clock edge with clk_en = 1 and mem_req = 1.
  - Read (mem_we = 0): data_out takes the addressed value on that edge and is valid for the next cycle.
  - Write (mem_we = 1): data_out holds.
- RAM, addresses 0..239: read/write byte. A read issued the cycle after a write to the same address returns the new value.
- MMIO map (W = write-only, R = read-only). Reads of W registers return 0. Writes to R registers are ignored.
  - 240 W: pixel X = data_in[4:0].
  - 241 W: pixel Y = data_in[4:0].
  - 242 W: set back[X][Y]; data is ignored.
  - 243 W: clear back[X][Y].
  - 244 R: returns {7'b0, back[X][Y]}.
  - 245 W: copy the whole back buffer to the front buffer in a single edge; the back buffer is unchanged.
  - 246 W: clear the back buffer; the front buffer is unchanged.
  - 247..249: reserved; reads return 0, writes are ignored.
  - 250 W: number_value = data_in, number_valid = 1.
  - 251 W: number_valid = 0; number_value is retained.
  - 252 W: number_signed = 1.
  - 253 W: number_signed = 0.
  - 254 R: returns the current LFSR value, then the LFSR advances on the same edge.
  - 255 R: returns the controller sample, a register loaded from controller on every clk_en cycle (one cycle delay).
- LFSR:
  - 8-bit Galois form with taps x^8+x^6+x^5+x^4+1, shifting right. When lfsr[0] = 1 the shifted value is XORed with 8'hB8.
  - Advances only on reads of address 254. It never reaches 0.
  - Period is 255.
- Boundary: X/Y truncate to 5 bits, so writing 8'hFF selects pixel 31.

Test Plan:
- Reset, then write 0x5A to address 17, then read address 17 -> data_out = 0x5A one cycle after the read edge; data_out = 0 after reset.
- Read address 17 with clk_en held low for 3 cycles, then raise clk_en -> data_out stays 0 while stalled and becomes 0x5A one edge after clk_en rises.
- Write 240 = 3, write 241 = 7, write 242, read 244 -> 0x01. Before writing 245, scr_x = 3, scr_y = 7 gives scr_pixel = 0. After writing 245, scr_pixel = 1. After writing 246, reading 244 returns 0 and scr_pixel stays 1.
- Three consecutive reads of address 254 from reset -> 0x01, 0xB8, 0x5C. The LFSR advances only on those reads; after 255 reads the sequence returns 0x01.
- Write 250 = 0xF6, then write 252 -> number_value = 0xF6, number_valid = 1, number_signed = 1. Write 251 -> number_valid = 0, number_value still 0xF6.
- Drive controller = 0x21, then read 255 two cycles later -> 0x21. Write 0xFF to 255 and 254 -> no state change. Assert sync_rst during a RAM read -> data_out = 0 the next cycle.
